// File: rtl/sd_resp_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sd_resp_rx_ctrl
// Description : SD-bus command-response receiver. Armed per command, it waits
//               a bounded number of clocks for the start bit, captures a short
//               or long response frame MSB-first, computes CRC7 serially while
//               receiving, then reports the frame and error flags on a
//               single-cycle done pulse.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               start            - arm request (honoured in IDLE only)
//               long_resp        - latched with start: long framing
//               check_crc        - latched with start: enable CRC check
//               sd_cmd           - sampled CMD line
//               response         - last complete frame, right-aligned
//               busy, done       - activity level / completion pulse
//               timeout_err, tx_err, end_err, crc_err - error flags
// Revision    : 1.0 - initial release
// ============================================================================
module sd_resp_rx_ctrl #(
    parameter int SHORT_BITS = 48,
    parameter int LONG_BITS  = 136,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 long_resp,
    input  logic                 check_crc,
    input  logic                 sd_cmd,
    output logic [LONG_BITS-1:0] response,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic                 tx_err,
    output logic                 end_err,
    output logic                 crc_err
);

    localparam int CNT_W  = $clog2(LONG_BITS + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    // Bit count values are "number of bits already received".
    localparam logic [CNT_W-1:0]  c_short_last      = CNT_W'(SHORT_BITS - 1);
    localparam logic [CNT_W-1:0]  c_long_last       = CNT_W'(LONG_BITS - 1);
    // Short frames: CRC covers frame bits SHORT_BITS-1..8.
    localparam logic [CNT_W-1:0]  c_short_crc_last  = CNT_W'(SHORT_BITS - 9);
    // Long frames: start, transmission and 6 reserved bits are skipped.
    localparam logic [CNT_W-1:0]  c_long_crc_first  = CNT_W'(8);
    localparam logic [CNT_W-1:0]  c_long_crc_last   = CNT_W'(LONG_BITS - 9);
    localparam logic [CNT_W-1:0]  c_cnt_one         = CNT_W'(1);
    localparam logic [WAIT_W-1:0] c_wait_last       = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] c_wait_one        = WAIT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_START = 2'd1,
        S_RECEIVE    = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_long;
    logic                 r_chk;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic [LONG_BITS-1:0] r_shift;
    logic [6:0]           r_crc;
    logic [LONG_BITS-1:0] r_response;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_timeout_err;
    logic                 r_tx_err;
    logic                 r_end_err;
    logic                 r_crc_err;

    logic [LONG_BITS-1:0] w_frame;
    logic                 w_last;
    logic                 w_crc_en;
    logic                 w_crc_fb;
    logic [6:0]           w_crc_next;
    logic                 w_tx_bit;

    // Frame including the bit being sampled on this edge.
    assign w_frame    = {r_shift[LONG_BITS-2:0], sd_cmd};
    assign w_last     = r_long ? (r_bit_cnt == c_long_last) : (r_bit_cnt == c_short_last);
    // The incoming bit is the (r_bit_cnt+1)-th bit of the frame.
    assign w_crc_en   = r_long ? ((r_bit_cnt >= c_long_crc_first) && (r_bit_cnt <= c_long_crc_last))
                               : (r_bit_cnt <= c_short_crc_last);
    // x^7 + x^3 + 1, MSB-first serial update.
    assign w_crc_fb   = r_crc[6] ^ sd_cmd;
    assign w_crc_next = {r_crc[5:3], r_crc[2] ^ w_crc_fb, r_crc[1:0], w_crc_fb};
    assign w_tx_bit   = r_long ? w_frame[LONG_BITS-2] : w_frame[SHORT_BITS-2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_long        <= 1'b0;
            r_chk         <= 1'b0;
            r_bit_cnt     <= '0;
            r_wait_cnt    <= '0;
            r_shift       <= '0;
            r_crc         <= '0;
            r_response    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_tx_err      <= 1'b0;
            r_end_err     <= 1'b0;
            r_crc_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is dropped so the
                    // sequencer sees a clean gap before re-arming.
                    if (start && !r_done) begin
                        r_long        <= long_resp;
                        r_chk         <= check_crc;
                        r_timeout_err <= 1'b0;
                        r_tx_err      <= 1'b0;
                        r_end_err     <= 1'b0;
                        r_crc_err     <= 1'b0;
                        r_wait_cnt    <= '0;
                        r_bit_cnt     <= '0;
                        r_shift       <= '0;
                        r_crc         <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    // The TIMEOUT-th sample is a timeout even if it is a start bit.
                    if (r_wait_cnt == c_wait_last) begin
                        r_wait_cnt    <= r_wait_cnt + c_wait_one;
                        r_timeout_err <= 1'b1;
                        r_done        <= 1'b1;
                        r_response    <= '0;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else if (!sd_cmd) begin
                        // Start bit is 0, so it leaves the CRC at its zero seed.
                        r_shift   <= w_frame;
                        r_bit_cnt <= c_cnt_one;
                        r_state   <= S_RECEIVE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_wait_one;
                    end
                end
                S_RECEIVE: begin
                    r_shift   <= w_frame;
                    r_bit_cnt <= r_bit_cnt + c_cnt_one;
                    if (w_crc_en) begin
                        r_crc <= w_crc_next;
                    end
                    if (w_last) begin
                        // Bits above the frame are zero: shift register was
                        // cleared on arm.
                        r_response <= w_frame;
                        r_tx_err   <= w_tx_bit;
                        r_end_err  <= ~sd_cmd;
                        r_crc_err  <= r_chk && (r_crc != w_frame[7:1]);
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign response    = r_response;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;
    assign tx_err      = r_tx_err;
    assign end_err     = r_end_err;
    assign crc_err     = r_crc_err;

endmodule
`default_nettype wire

// File: tb/tb_sd_resp_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_resp_rx_ctrl
// Description : Scoreboard bench for sd_resp_rx_ctrl. Stimulus pushes the
//               expected frame, flags and completion cycle; a monitor pops
//               and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_resp_rx_ctrl;

    localparam int SB  = 48;
    localparam int LB  = 136;
    localparam int TO  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          long_resp;
    logic          check_crc;
    logic          sd_cmd;
    logic [LB-1:0] response;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic          tx_err;
    logic          end_err;
    logic          crc_err;

    sd_resp_rx_ctrl #(
        .SHORT_BITS (SB),
        .LONG_BITS  (LB),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .long_resp   (long_resp),
        .check_crc   (check_crc),
        .sd_cmd      (sd_cmd),
        .response    (response),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .tx_err      (tx_err),
        .end_err     (end_err),
        .crc_err     (crc_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LB-1:0] resp;
        logic [3:0]    flags;   // {timeout, tx, end, crc}
        int            cyc;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   t_arm  = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_width: done high on two consecutive cycles at cyc %0d", cyc);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL done_busy: busy=%b while done, required 0", busy);
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done at cyc %0d with no pending expectation", cyc);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (response !== e.resp) begin
                    errors++;
                    $display("FAIL %s response: got %h required %h", e.name, response, e.resp);
                end
                checks++;
                if ({timeout_err, tx_err, end_err, crc_err} !== e.flags) begin
                    errors++;
                    $display("FAIL %s flags{to,tx,end,crc}: got %b required %b", e.name,
                             {timeout_err, tx_err, end_err, crc_err}, e.flags);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL %s done_cycle: got %0d required %0d", e.name, cyc, e.cyc);
                end
            end
        end
        prev_done <= done;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, expv);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [LB-1:0] f, input int hi, input int lo);
        logic [6:0] c = 7'd0;
        logic       fb;
        for (int i = hi; i >= lo; i--) begin
            fb = c[6] ^ f[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic arm(input logic l, input logic c);
        start     = 1'b1;
        long_resp = l;
        check_crc = c;
        @(posedge clk); #1;
        start = 1'b0;
        t_arm = cyc;
    endtask

    task automatic push(input logic [LB-1:0] r, input logic [3:0] fl, input int at, input string nm);
        exp_t e;
        e.resp = r; e.flags = fl; e.cyc = at; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Idle for 'dly' samples, then the frame MSB-first; start bit at t_arm+dly+1.
    task automatic send_frame(input logic [LB-1:0] f, input int len, input int dly,
                              input logic [3:0] fl, input string nm);
        push(f, fl, t_arm + dly + 1 + len - 1, nm);
        for (int k = 0; k < dly; k++) begin
            sd_cmd = 1'b1;
            @(posedge clk); #1;
        end
        for (int i = len - 1; i >= 0; i--) begin
            sd_cmd = f[i];
            @(posedge clk); #1;
        end
        sd_cmd = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d expectations pending, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    logic [LB-1:0] f55, fr3, fr2, f;
    initial begin
        f55 = '0; f55[47:0] = 48'h370000012083;
        fr3 = '0; fr3[47:0] = 48'h3F00FF8000FF;
        fr2 = '0;
        fr2[133:128] = 6'h3F;
        fr2[127:8]   = 120'h035344534431364780123456789ABC;
        fr2[7:1]     = crc7(fr2, 127, 8);
        fr2[0]       = 1'b1;

        reset = 1'b1; start = 1'b0; long_resp = 1'b0; check_crc = 1'b0; sd_cmd = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("reset_response", response, '0);
        chk("reset_busy_done", {134'd0, busy, done}, '0);
        chk("reset_flags", {132'd0, timeout_err, tx_err, end_err, crc_err}, '0);

        // CMD55 R1, clean
        arm(1'b0, 1'b1);
        chk("arm_busy", {135'd0, busy}, {135'd0, 1'b1});
        send_frame(f55, SB, 5, 4'b0000, "r1_ok");
        drain();

        // Bit 20 corrupted
        f = f55; f[20] = ~f[20];
        arm(1'b0, 1'b1);
        send_frame(f, SB, 3, 4'b0001, "r1_crc_bad");
        drain();

        // R3 without and with CRC check
        arm(1'b0, 1'b0);
        send_frame(fr3, SB, 1, 4'b0000, "r3_nochk");
        drain();
        arm(1'b0, 1'b1);
        send_frame(fr3, SB, 0, 4'b0001, "r3_chk");
        drain();

        // R2 clean, end bit forced 0, transmission bit forced 1
        arm(1'b1, 1'b1);
        send_frame(fr2, LB, 7, 4'b0000, "r2_ok");
        drain();
        f = fr2; f[0] = 1'b0;
        arm(1'b1, 1'b1);
        send_frame(f, LB, 2, 4'b0010, "r2_end_bad");
        drain();
        f = fr2; f[134] = 1'b1;
        arm(1'b1, 1'b1);
        send_frame(f, LB, 2, 4'b0100, "r2_tx_bad");
        drain();

        // Timeout, start in done cycle ignored, start next cycle accepted
        sd_cmd = 1'b1;
        arm(1'b0, 1'b1);
        push('0, 4'b1000, t_arm + TO, "timeout");
        begin
            int n = 0;
            @(negedge clk);
            while (!done && n < TO + 10) begin
                @(negedge clk);
                n++;
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL timeout_wait: done not seen, required at cyc %0d", t_arm + TO);
                exp_q.delete();
            end
        end
        start = 1'b1; long_resp = 1'b0; check_crc = 1'b1;
        @(posedge clk); #1;
        chk("start_in_done_ignored", {135'd0, busy}, '0);
        @(posedge clk); #1;
        start = 1'b0;
        t_arm = cyc;
        chk("start_after_done_busy", {135'd0, busy}, {135'd0, 1'b1});
        send_frame(f55, SB, 2, 4'b0000, "rearm_after_timeout");
        drain();

        // Reset at bit 30 of a short frame
        arm(1'b0, 1'b1);
        sd_cmd = 1'b1;
        @(posedge clk); #1;
        for (int i = SB - 1; i >= SB - 30; i--) begin
            sd_cmd = f55[i];
            @(posedge clk); #1;
        end
        reset = 1'b1;
        sd_cmd = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_response", response, '0);
        chk("abort_busy_done", {134'd0, busy, done}, '0);
        chk("abort_flags", {132'd0, timeout_err, tx_err, end_err, crc_err}, '0);
        repeat (SB + 10) begin
            @(posedge clk); #1;
        end
        chk("abort_still_idle", {135'd0, busy}, '0);
        arm(1'b0, 1'b1);
        send_frame(f55, SB, 4, 4'b0000, "after_abort");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
